// File: rtl/sysid_checker.sv
// Avalon-MM read master: reads system ID (word 0) and build timestamp (word 1) and flags a stale image.
// Optional periodic re-check and error counter are enabled with `define SYSID_CHECKER_PERIODIC_EN.
module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1316073944,
  parameter int          READ_LATENCY       = 0,
  parameter int          PERIOD_CYCLES      = 1000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_ok,
  output logic        ts_ok,
  output logic [31:0] captured_id,
  output logic [31:0] captured_ts,
  output logic [2:0]  fsm_state
`ifdef SYSID_CHECKER_PERIODIC_EN
  ,
  output logic [7:0]  err_count
`endif
);

  // Read handshake: avm_read is a single-cycle strobe; readdata is taken exactly
  // READ_LATENCY cycles after the strobe (same cycle when READ_LATENCY is 0).
  typedef enum logic [2:0] {IDLE, RD_ID, WAIT_ID, RD_TS, WAIT_TS, CMP} state_t;

  localparam bit         ZERO_LAT = (READ_LATENCY == 0);
  localparam logic [2:0] LAT_LAST = (READ_LATENCY > 0) ? 3'(READ_LATENCY - 1) : 3'd0;

  state_t     state;
  logic [2:0] lat_cnt;
  logic       start_req;
  logic       id_match;
  logic       ts_match;

  assign fsm_state = state;
  assign id_match  = (captured_id == EXPECTED_ID);
  assign ts_match  = (captured_ts == EXPECTED_TIMESTAMP);

`ifdef SYSID_CHECKER_PERIODIC_EN
  localparam logic [31:0] PERIOD_LAST = 32'(PERIOD_CYCLES - 1);
  logic [31:0] period_cnt;
  logic        period_tick;

  assign period_tick = (period_cnt == PERIOD_LAST);
  assign start_req   = start | period_tick;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      period_cnt <= '0;
    end else if (period_tick) begin
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt + 32'd1;
    end
  end

  // Counts failing checks; saturates so a long-running stale image stays visible.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_count <= '0;
    end else if (state == CMP && !(id_match && ts_match) && err_count != 8'hFF) begin
      err_count <= err_count + 8'd1;
    end
  end
`else
  assign start_req = start;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      lat_cnt     <= '0;
      avm_address <= 1'b0;
      avm_read    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      id_ok       <= 1'b0;
      ts_ok       <= 1'b0;
      captured_id <= '0;
      captured_ts <= '0;
    end else begin
      done     <= 1'b0;
      avm_read <= 1'b0;
      case (state)
        IDLE: begin
          if (start_req) begin
            state       <= RD_ID;
            avm_read    <= 1'b1;
            avm_address <= 1'b0;
            busy        <= 1'b1;
          end
        end
        RD_ID: begin
          lat_cnt <= '0;
          if (ZERO_LAT) begin
            captured_id <= avm_readdata;
            state       <= RD_TS;
            avm_read    <= 1'b1;
            avm_address <= 1'b1;
          end else begin
            state <= WAIT_ID;
          end
        end
        WAIT_ID: begin
          if (lat_cnt == LAT_LAST) begin
            captured_id <= avm_readdata;
            lat_cnt     <= '0;
            state       <= RD_TS;
            avm_read    <= 1'b1;
            avm_address <= 1'b1;
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
          end
        end
        RD_TS: begin
          lat_cnt <= '0;
          if (ZERO_LAT) begin
            captured_ts <= avm_readdata;
            state       <= CMP;
          end else begin
            state <= WAIT_TS;
          end
        end
        WAIT_TS: begin
          if (lat_cnt == LAT_LAST) begin
            captured_ts <= avm_readdata;
            lat_cnt     <= '0;
            state       <= CMP;
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
          end
        end
        CMP: begin
          id_ok <= id_match;
          ts_ok <= ts_match;
          pass  <= id_match && ts_match;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sysid_checker.sv
// Directed bench for sysid_checker: latencies 0, 2 and 3, start filtering, mid-check reset,
// and (when SYSID_CHECKER_PERIODIC_EN is defined) periodic checks with err_count.
module tb_sysid_checker;

  localparam logic [31:0] TS_GOOD = 32'd1316073944;
  localparam logic [31:0] TS_BAD  = 32'h4E71_0000;
  localparam logic [31:0] ID3     = 32'hC0DE_0003;
  localparam logic [31:0] JUNK    = 32'hDEAD_BEEF;

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic rst3  = 1'b1;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // DUT signals: u0 (L=0), u2 (L=2), u3 (L=3, own reset)
  logic start0, rd0, addr0, busy0, done0, pass0, idok0, tsok0;
  logic start2, rd2, addr2, busy2, done2, pass2, idok2, tsok2;
  logic start3, rd3, addr3, busy3, done3, pass3, idok3, tsok3;
  logic [31:0] rdata0, rdata2, rdata3, cid0, cts0, cid2, cts2, cid3, cts3;
  logic [2:0]  st0, st2, st3;
  logic [31:0] ts0_val = TS_GOOD;
  logic [31:0] p2 [2];
  logic [31:0] p3 [3];

  // slave models: combinational for u0, registered pipelines for u2/u3
  assign rdata0 = rd0 ? (addr0 ? ts0_val : 32'd0) : JUNK;
  always @(posedge clock) begin
    p2[0] <= rd2 ? (addr2 ? TS_GOOD : 32'd0) : JUNK;
    p2[1] <= p2[0];
    p3[0] <= rd3 ? (addr3 ? TS_GOOD : ID3) : JUNK;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign rdata2 = p2[1];
  assign rdata3 = p3[2];

`ifdef SYSID_CHECKER_PERIODIC_EN
  logic [7:0] err0, err2, err3, errp;
  logic startp = 1'b0;
  logic rdp, addrp, busyp, donep, passp, idokp, tsokp;
  logic [31:0] rdatap, cidp, ctsp;
  logic [2:0] stp;
  int done_cycp[$];
  assign rdatap = rdp ? (addrp ? TS_BAD : 32'd0) : JUNK;
  always @(negedge clock) if (donep === 1'b1) done_cycp.push_back(cyc);

  sysid_checker #(.READ_LATENCY(0), .PERIOD_CYCLES(50)) up (
    .clock(clock), .reset(reset), .start(startp), .avm_address(addrp), .avm_read(rdp),
    .avm_readdata(rdatap), .busy(busyp), .done(donep), .pass(passp), .id_ok(idokp),
    .ts_ok(tsokp), .captured_id(cidp), .captured_ts(ctsp), .fsm_state(stp), .err_count(errp));
`endif

  sysid_checker #(.READ_LATENCY(0)) u0 (
    .clock(clock), .reset(reset), .start(start0), .avm_address(addr0), .avm_read(rd0),
    .avm_readdata(rdata0), .busy(busy0), .done(done0), .pass(pass0), .id_ok(idok0),
    .ts_ok(tsok0), .captured_id(cid0), .captured_ts(cts0), .fsm_state(st0)
`ifdef SYSID_CHECKER_PERIODIC_EN
    , .err_count(err0)
`endif
  );

  sysid_checker #(.READ_LATENCY(2)) u2 (
    .clock(clock), .reset(reset), .start(start2), .avm_address(addr2), .avm_read(rd2),
    .avm_readdata(rdata2), .busy(busy2), .done(done2), .pass(pass2), .id_ok(idok2),
    .ts_ok(tsok2), .captured_id(cid2), .captured_ts(cts2), .fsm_state(st2)
`ifdef SYSID_CHECKER_PERIODIC_EN
    , .err_count(err2)
`endif
  );

  sysid_checker #(.EXPECTED_ID(ID3), .READ_LATENCY(3)) u3 (
    .clock(clock), .reset(rst3), .start(start3), .avm_address(addr3), .avm_read(rd3),
    .avm_readdata(rdata3), .busy(busy3), .done(done3), .pass(pass3), .id_ok(idok3),
    .ts_ok(tsok3), .captured_id(cid3), .captured_ts(cts3), .fsm_state(st3)
`ifdef SYSID_CHECKER_PERIODIC_EN
    , .err_count(err3)
`endif
  );

  // strobe / done / busy logs, sampled mid-cycle
  int   rd_cyc0[$], rd_cyc2[$], done_cyc0[$], done_cyc2[$], done_cyc3[$];
  logic rd_adr0[$], rd_adr2[$];
  int   busy_n2 = 0;
  always @(negedge clock) begin
    if (rd0 === 1'b1) begin rd_cyc0.push_back(cyc); rd_adr0.push_back(addr0); end
    if (rd2 === 1'b1) begin rd_cyc2.push_back(cyc); rd_adr2.push_back(addr2); end
    if (done0 === 1'b1) done_cyc0.push_back(cyc);
    if (done2 === 1'b1) done_cyc2.push_back(cyc);
    if (done3 === 1'b1) done_cyc3.push_back(cyc);
    if (busy2 === 1'b1) busy_n2 <= busy_n2 + 1;
  end

  // driver helpers
  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic sample_at(input int n);
    wait_cyc(n);
    @(negedge clock);
  endtask

  // scoreboard comparison
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    start0 = 1'b0; start2 = 1'b0; start3 = 1'b0;

    sample_at(2);
    check("rst_read", {31'd0, rd0}, 32'd0);
    check("rst_addr", {31'd0, addr0}, 32'd0);
    check("rst_busy", {31'd0, busy0}, 32'd0);
    check("rst_done", {31'd0, done0}, 32'd0);
    check("rst_flags", {29'd0, pass0, idok0, tsok0}, 32'd0);
    check("rst_cts", cts0, 32'd0);
    check("rst_cid3", cid3, 32'd0);
    check("rst_state", {29'd0, st2}, 32'd0);

    wait_cyc(4);
    reset = 1'b0;
    rst3  = 1'b0;

    // first checks: u0 and u2 good slaves, u3 good slave with non-zero ID
    wait_cyc(10);
    start0 = 1'b1; start2 = 1'b1; start3 = 1'b1;
    sample_at(10);
    check("l2_busy_before", {31'd0, busy2}, 32'd0);
    wait_cyc(11);
    start0 = 1'b0; start2 = 1'b0; start3 = 1'b0;
    sample_at(11);
    check("l0_rd_id", {30'd0, rd0, addr0}, 32'd2);
    check("l2_busy_first", {31'd0, busy2}, 32'd1);
    wait_cyc(12);
    start2 = 1'b1;
    sample_at(12);
    check("l0_rd_ts", {30'd0, rd0, addr0}, 32'd3);
    wait_cyc(13);
    start2 = 1'b0;
    sample_at(14);
    check("l0_done", {31'd0, done0}, 32'd1);
    check("l0_flags", {29'd0, pass0, idok0, tsok0}, 32'd7);
    check("l0_cts", cts0, TS_GOOD);
    check("l0_busy_after", {31'd0, busy0}, 32'd0);
    sample_at(17);
    check("l2_busy_last", {31'd0, busy2}, 32'd1);
    check("l2_done_early", {31'd0, done2}, 32'd0);

    // u2 done at 18; coincident start launches a second check
    wait_cyc(18);
    start2 = 1'b1;
    sample_at(18);
    check("l2_done", {31'd0, done2}, 32'd1);
    check("l2_busy_done", {31'd0, busy2}, 32'd0);
    check("l2_pass", {29'd0, pass2, idok2, tsok2}, 32'd7);
    wait_cyc(19);
    start2 = 1'b0;

    // u0 second check against a stale timestamp
    wait_cyc(20);
    ts0_val = TS_BAD;
    start0 = 1'b1;
    sample_at(20);
    check("l3_done", {31'd0, done3}, 32'd1);
    check("l3_pass", {31'd0, pass3}, 32'd1);
    check("l3_cid", cid3, ID3);
    wait_cyc(21);
    start0 = 1'b0;
    sample_at(22);
    check("l0_hold_pass", {31'd0, pass0}, 32'd1);
    check("l0_hold_cts", cts0, TS_GOOD);
    sample_at(24);
    check("l0_bad_done", {31'd0, done0}, 32'd1);
    check("l0_bad_flags", {29'd0, pass0, idok0, tsok0}, 32'd2);
    check("l0_bad_cts", cts0, TS_BAD);
    sample_at(26);
    check("l2_done2", {31'd0, done2}, 32'd1);

    sample_at(30);
    check("l0_rd_n", rd_cyc0.size(), 32'd4);
    check("l0_rd_c0", rd_cyc0[0], 32'd11);
    check("l0_rd_c1", rd_cyc0[1], 32'd12);
    check("l0_rd_c2", rd_cyc0[2], 32'd21);
    check("l0_rd_a", {28'd0, rd_adr0[0], rd_adr0[1], rd_adr0[2], rd_adr0[3]}, 32'h5);
    check("l0_done_n", done_cyc0.size(), 32'd2);
    check("l2_rd_n", rd_cyc2.size(), 32'd4);
    check("l2_rd_c1", rd_cyc2[1], 32'd14);
    check("l2_rd_c2", rd_cyc2[2], 32'd19);
    check("l2_rd_c3", rd_cyc2[3], 32'd22);
    check("l2_rd_a", {28'd0, rd_adr2[0], rd_adr2[1], rd_adr2[2], rd_adr2[3]}, 32'h5);
    check("l2_done_n", done_cyc2.size(), 32'd2);
    check("l2_done_c1", done_cyc2[1], 32'd26);
    check("l2_busy_n", busy_n2, 32'd14);
`ifdef SYSID_CHECKER_PERIODIC_EN
    check("err0_one", {24'd0, err0}, 32'd1);
    check("err2_zero", {24'd0, err2}, 32'd0);
`endif

    // u3: reset while in WAIT_ID clears everything, no done pulse
    wait_cyc(40);
    start3 = 1'b1;
    wait_cyc(41);
    start3 = 1'b0;
    sample_at(41);
    check("l3_rd", {31'd0, rd3}, 32'd1);
    sample_at(42);
    check("l3_wait_busy", {30'd0, busy3, rd3}, 32'd2);
    wait_cyc(43);
    rst3 = 1'b1;
    #1;
    check("mid_rst_rd_busy", {30'd0, rd3, busy3}, 32'd0);
    check("mid_rst_flags", {29'd0, pass3, idok3, tsok3}, 32'd0);
    check("mid_rst_cid", cid3, 32'd0);
    check("mid_rst_cts", cts3, 32'd0);
    check("mid_rst_state", {29'd0, st3}, 32'd0);
    wait_cyc(45);
    rst3 = 1'b0;
    wait_cyc(50);
    start3 = 1'b1;
    wait_cyc(51);
    start3 = 1'b0;
    sample_at(60);
    check("l3_again_done", {31'd0, done3}, 32'd1);
    check("l3_again_pass", {29'd0, pass3, idok3, tsok3}, 32'd7);
    check("l3_again_cid", cid3, ID3);
    sample_at(62);
    check("l3_done_n", done_cyc3.size(), 32'd2);
    check("l3_done_c1", done_cyc3[1], 32'd60);

`ifdef SYSID_CHECKER_PERIODIC_EN
    // periodic instance: mismatching slave, start port never pulsed
    sample_at(160);
    check("per_done_n", done_cycp.size(), 32'd3);
    check("per_gap1", done_cycp[1] - done_cycp[0], 32'd50);
    check("per_gap2", done_cycp[2] - done_cycp[1], 32'd50);
    check("per_err3", {24'd0, errp}, 32'd3);
    sample_at(13300);
    check("per_many", {31'd0, done_cycp.size() > 256}, 32'd1);
    check("per_err_sat", {24'd0, errp}, 32'd255);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
